// File: rtl/push_wait_fifo_source.sv
// push_wait_fifo_source: buffered push/wait_n initiator.
// Upstream words are queued in a 2**g_depth_log2 entry FIFO, and the head word is presented
// downstream on registered outputs. The queue depth includes the presented word.
// After reset is released, a four-edge stretch holds the block in its reset state.
module push_wait_fifo_source #(
    parameter int unsigned g_data_size  = 8,
    parameter int unsigned g_depth_log2 = 2
) (
    input  logic                     p_clock,
    input  logic                     p_reset_n,
    input  logic                     p_s_push,
    input  logic [g_data_size-1:0]   p_s_data,
    output logic                     p_s_wait_n,
    output logic                     p_m_push,
    output logic [g_data_size-1:0]   p_m_data,
    input  logic                     p_m_wait_n,
    output logic [g_depth_log2:0]    p_level
);

    localparam int unsigned Depth = 2 ** g_depth_log2;

    typedef logic [g_depth_log2-1:0] ptr_t;
    typedef logic [g_depth_log2:0]   lvl_t;

    localparam lvl_t DepthLvl = lvl_t'(Depth);

    logic [g_data_size-1:0] mem [Depth];

    ptr_t                   wr_ptr_q, wr_ptr_d;
    ptr_t                   rd_ptr_q, rd_ptr_d;
    lvl_t                   level_q, level_d;
    logic [3:0]             stretch_q;
    logic                   s_wait_n_q, s_wait_n_d;
    logic                   m_push_q, m_push_d;
    logic [g_data_size-1:0] m_data_q, m_data_d;
    logic                   hold;
    logic                   in_xfer;
    logic                   out_xfer;

    // The stretch LSB stays high for edges 1..4 after release.
    assign hold     = stretch_q[0];
    assign in_xfer  = p_s_push & s_wait_n_q;
    assign out_xfer = m_push_q & p_m_wait_n;

    assign p_s_wait_n = s_wait_n_q;
    assign p_m_push   = m_push_q;
    assign p_m_data   = m_data_q;
    assign p_level    = level_q;

    // Compute the next queue state and the registered outputs.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        s_wait_n_d = s_wait_n_q;
        m_push_d   = m_push_q;
        m_data_d   = m_data_q;
        if (hold) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            level_d    = '0;
            s_wait_n_d = 1'b0;
            m_push_d   = 1'b0;
            m_data_d   = '0;
        end else begin
            if (in_xfer) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (out_xfer) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            level_d    = level_q + lvl_t'(in_xfer) - lvl_t'(out_xfer);
            s_wait_n_d = (level_d < DepthLvl);
            m_push_d   = (level_d != '0);
            // When the queue empties (or is empty) as a word arrives, that word becomes the
            // head, and it has not been written to mem yet.
            if (in_xfer && ((level_q - lvl_t'(out_xfer)) == '0)) begin
                m_data_d = p_s_data;
            end else if (level_d != '0) begin
                m_data_d = mem[rd_ptr_d];
            end
        end
    end

    // Reset-stretch shift register. It loads all ones and then drains towards zero.
    always_ff @(posedge p_clock or negedge p_reset_n) begin
        if (!p_reset_n) begin
            stretch_q <= 4'hF;
        end else begin
            stretch_q <= {1'b0, stretch_q[3:1]};
        end
    end

    // Control and output registers.
    always_ff @(posedge p_clock or negedge p_reset_n) begin
        if (!p_reset_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            s_wait_n_q <= 1'b0;
            m_push_q   <= 1'b0;
            m_data_q   <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            s_wait_n_q <= s_wait_n_d;
            m_push_q   <= m_push_d;
            m_data_q   <= m_data_d;
        end
    end

    // Storage array. It has no reset, because the level and pointers decide what is valid.
    always_ff @(posedge p_clock) begin
        if (in_xfer) begin
            mem[wr_ptr_q] <= p_s_data;
        end
    end

endmodule
